// File: rtl/sdram_cmd_pkg.sv
// Shared types and constants for the SDRAM half-word command master.
// The FSM state enum, the command bundle and the helper that builds one half-word command.
package sdram_cmd_pkg;

    typedef enum logic [2:0] {IDLE, LO, HI, RWAIT, RESP} state_t;

    localparam int unsigned HALF_BYTES = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam logic [1:0]  DQM_IDLE   = 2'b11;

    typedef struct packed {
        logic        valid;
        logic        wen;
        logic [1:0]  dqm_n;
        logic [31:0] addr;
        logic [15:0] wdata;
    } cmd_t;

    localparam cmd_t CMD_IDLE = '{valid: 1'b0, wen: 1'b0, dqm_n: DQM_IDLE,
                                  addr: 32'h0, wdata: 16'h0};

    // Reads always fetch both bytes of a half, so their masks are fully enabled.
    function automatic cmd_t half_cmd(input logic        hi,
                                      input logic        wen,
                                      input logic [31:0] a,
                                      input logic [31:0] wdata,
                                      input logic [3:0]  wstrb);
        cmd_t c;
        c.valid = 1'b1;
        c.wen   = wen;
        c.addr  = hi ? a + 32'(HALF_BYTES) : a;
        c.dqm_n = !wen ? 2'b00 : (hi ? ~wstrb[3:2] : ~wstrb[1:0]);
        c.wdata = !wen ? 16'h0 : (hi ? wdata[31:16] : wdata[15:0]);
        return c;
    endfunction

endpackage

// File: rtl/sdram_cmd_master.sv
// Splits 32-bit word requests into one or two 16-bit SDRAM commands and
// assembles read data from the half-word responses.
module sdram_cmd_master
    import sdram_cmd_pkg::*;
#(
    parameter bit SKIP_MASKED_HALF = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        cmd_valid,
    output logic        cmd_wen,
    output logic [1:0]  cmd_dqm_n,
    output logic [31:0] cmd_addr,
    output logic [15:0] cmd_wdata,
    input  logic [15:0] cmd_rdata
);

    state_t      state;
    logic        txn_wen;
    logic [31:0] txn_addr;
    logic [31:0] txn_wdata;
    logic [3:0]  txn_wstrb;
    logic [31:0] rdata;
    cmd_t        cmd;

    logic [31:0] acc_addr;
    logic        acc_skip_all;
    logic        acc_skip_lo;
    logic        skip_hi;

    assign acc_addr     = req_addr & ~32'(WORD_BYTES - 1);
    assign acc_skip_all = SKIP_MASKED_HALF && req_wen && (req_wstrb == 4'b0000);
    assign acc_skip_lo  = SKIP_MASKED_HALF && req_wen && (req_wstrb[1:0] == 2'b00);
    assign skip_hi      = SKIP_MASKED_HALF && txn_wen && (txn_wstrb[3:2] == 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            txn_wen    <= 1'b0;
            txn_addr   <= 32'h0;
            txn_wdata  <= 32'h0;
            txn_wstrb  <= 4'h0;
            rdata      <= 32'h0;
            cmd        <= CMD_IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        txn_wen   <= req_wen;
                        txn_addr  <= acc_addr;
                        txn_wdata <= req_wdata;
                        txn_wstrb <= req_wstrb;
                        rdata     <= 32'h0;
                        if (acc_skip_all) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else if (acc_skip_lo) begin
                            state <= HI;
                            cmd   <= half_cmd(1'b1, req_wen, acc_addr, req_wdata, req_wstrb);
                        end else begin
                            state <= LO;
                            cmd   <= half_cmd(1'b0, req_wen, acc_addr, req_wdata, req_wstrb);
                        end
                    end
                end
                LO: begin
                    if (skip_hi) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        cmd        <= CMD_IDLE;
                    end else begin
                        state <= HI;
                        cmd   <= half_cmd(1'b1, txn_wen, txn_addr, txn_wdata, txn_wstrb);
                    end
                end
                HI: begin
                    // Data for a LO read arrives while HI is on the bus.
                    if (!txn_wen) begin
                        rdata[15:0] <= cmd_rdata;
                    end
                    cmd        <= CMD_IDLE;
                    state      <= txn_wen ? RESP : RWAIT;
                    resp_valid <= txn_wen;
                end
                RWAIT: begin
                    rdata[31:16] <= cmd_rdata;
                    state        <= RESP;
                    resp_valid   <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    cmd        <= CMD_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid  = cmd.valid;
    assign cmd_wen    = cmd.wen;
    assign cmd_dqm_n  = cmd.dqm_n;
    assign cmd_addr   = cmd.addr;
    assign cmd_wdata  = cmd.wdata;
    assign resp_rdata = rdata;

endmodule

// File: tb/tb_sdram_cmd_master.sv
// Scoreboard bench for sdram_cmd_master: a behavioural half-word SDRAM responder,
// a byte-level reference memory, and queues of expected commands and responses.
module tb_sdram_cmd_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        cmd_valid, cmd_wen;
    logic [1:0]  cmd_dqm_n;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [15:0] cmd_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    logic [50:0] exp_cmd[$];
    logic [31:0] exp_resp[$];
    logic [15:0] sdram[logic [30:0]];
    logic [7:0]  ref_mem[logic [31:0]];

    sdram_cmd_master dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .cmd_valid  (cmd_valid),
        .cmd_wen    (cmd_wen),
        .cmd_dqm_n  (cmd_dqm_n),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_rdata  (cmd_rdata)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rd_half(input logic [30:0] h);
        return sdram.exists(h) ? sdram[h] : 16'h0;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        sdram[a[31:1]]        = w[15:0];
        sdram[a[31:1] + 31'd1] = w[31:16];
        for (int i = 0; i < 4; i++) ref_mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    // Responder: read data appears only in the cycle after a read command, junk otherwise.
    initial begin
        logic [15:0] nxt;
        logic [15:0] cur;
        cmd_rdata = 16'h0;
        forever begin
            @(negedge clock);
            nxt = 16'($urandom);
            if (cmd_valid === 1'b1) begin
                if (cmd_wen) begin
                    cur = rd_half(cmd_addr[31:1]);
                    if (!cmd_dqm_n[0]) cur[7:0]  = cmd_wdata[7:0];
                    if (!cmd_dqm_n[1]) cur[15:8] = cmd_wdata[15:8];
                    sdram[cmd_addr[31:1]] = cur;
                end else begin
                    nxt = rd_half(cmd_addr[31:1]);
                end
            end
            @(posedge clock);
            #1 cmd_rdata = nxt;
        end
    end

    // Command monitor
    always @(negedge clock) begin
        if (mon_en) begin
            if (cmd_valid === 1'b1) begin
                if (exp_cmd.size() == 0) begin
                    check_eq("cmd_unexpected", 64'(cmd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check_eq("cmd", 64'({cmd_wen, cmd_dqm_n, cmd_addr, cmd_wdata}),
                             64'(exp_cmd.pop_front()));
                end
            end else begin
                check_eq("cmd_idle", 64'({cmd_valid, cmd_wen, cmd_dqm_n, cmd_addr, cmd_wdata}),
                         64'({1'b0, 1'b0, 2'b11, 32'h0, 16'h0}));
            end
        end
    end

    task automatic push_cmds(input logic wen, input logic [31:0] a, input logic [31:0] wdata,
                             input logic [3:0] strb);
        bit lo, hi;
        lo = !wen || (strb[1:0] != 2'b00);
        hi = !wen || (strb[3:2] != 2'b00);
        if (lo) exp_cmd.push_back({wen, wen ? ~strb[1:0] : 2'b00, a, wen ? wdata[15:0] : 16'h0});
        if (hi) exp_cmd.push_back({wen, wen ? ~strb[3:2] : 2'b00, a + 32'd2,
                                   wen ? wdata[31:16] : 16'h0});
    endtask

    // Call at a negedge; returns at a negedge after the response handshake.
    task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold);
        logic [31:0] a;
        logic [31:0] exp_rd;
        int          lat;
        int          n;
        a = {addr[31:2], 2'b00};
        push_cmds(wen, a, wdata, strb);
        if (wen) begin
            for (int i = 0; i < 4; i++) if (strb[i]) ref_mem[a + 32'(i)] = wdata[8*i +: 8];
            exp_rd = 32'h0;
            lat = 1 + int'(strb[1:0] != 2'b00) + int'(strb[3:2] != 2'b00);
        end else begin
            exp_rd = {ref_byte(a + 32'd3), ref_byte(a + 32'd2), ref_byte(a + 32'd1), ref_byte(a)};
            lat = 4;
        end
        exp_resp.push_back(exp_rd);

        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check_eq("req_ready_idle", 64'(req_ready), 64'(1));
        @(posedge clock);
        #1 req_valid = 1'b0;

        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (resp_valid !== 1'b1 && n < 20);
        check_eq("latency", 64'(n), 64'(lat));

        for (int i = 0; i < hold; i++) begin
            check_eq("hold_valid", 64'(resp_valid), 64'(1));
            check_eq("hold_rdata", 64'(resp_rdata), 64'(exp_rd));
            check_eq("hold_req_ready", 64'(req_ready), 64'(0));
            @(negedge clock);
        end
        check_eq("resp_rdata", 64'(resp_rdata), 64'(exp_resp.pop_front()));
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        @(negedge clock);
        check_eq("post_resp_valid", 64'(resp_valid), 64'(0));
        check_eq("post_req_ready", 64'(req_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_wstrb  = 4'h0;
        resp_ready = 1'b0;
        preload(32'h0000_0100, 32'h1122_3344);
        preload(32'hFFFF_FFFC, 32'h5566_7788);
        preload(32'h0000_0400, 32'hCAFE_BABE);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        mon_en = 1'b1;
        check_eq("rst_req_ready", 64'(req_ready), 64'(1));
        check_eq("rst_resp_valid", 64'(resp_valid), 64'(0));
        check_eq("rst_resp_rdata", 64'(resp_rdata), 64'(0));

        do_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0);
        do_txn(1'b1, 32'h0000_0200, 32'hAABB_CCDD, 4'b0110, 0);
        do_txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, 0);
        do_txn(1'b1, 32'h0000_0300, 32'h1234_5678, 4'b1100, 0);
        do_txn(1'b1, 32'h0000_0308, 32'h1234_5678, 4'b0000, 0);
        do_txn(1'b1, 32'h0000_0313, 32'h9ABC_DEF0, 4'b0011, 0);
        do_txn(1'b0, 32'h0000_0300, 32'h0, 4'h0, 5);
        do_txn(1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 0);

        // Reset while the HI command of a read is on the bus.
        push_cmds(1'b0, 32'h0000_0400, 32'h0, 4'h0);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h0000_0400;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_eq("hi_cmd_valid", 64'(cmd_valid), 64'(1));
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("abort_resp_valid", 64'(resp_valid), 64'(0));
            check_eq("abort_req_ready", 64'(req_ready), 64'(1));
            check_eq("abort_rdata", 64'(resp_rdata), 64'(0));
        end
        do_txn(1'b0, 32'h0000_0400, 32'h0, 4'h0, 0);

        for (int i = 0; i < 16; i++) begin
            ra = 32'h0000_0500 + 32'($urandom_range(0, 3) * 4);
            do_txn(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom), $urandom_range(0, 2));
        end

        repeat (2) @(negedge clock);
        check_eq("cmd_queue_empty", 64'(exp_cmd.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
